mdio_master_mc: RTL and testbench
=================================

Name: mdio_master_mc

Overview:
Parametrised multi-channel MDIO (IEEE 802.3 Clause 22) master with an internal MDC divider and a valid/ready command/response interface.
- Serves C_NUM_CHANNELS independent MDIO buses, one transaction at a time, routed by channel index.
- Sits between a register front-end or CPU sequencer and the per-port PHY tristate buffers, which are instantiated outside this block.
- Adds channel count, runtime error reporting, preamble suppression and optional Clause 45 support.

Parameters:
C_NUM_CHANNELS, 2, number of MDIO buses (1..16)
C_CH_WIDTH, 4, width of cmd_channel; must satisfy 2^C_CH_WIDTH >= C_NUM_CHANNELS
C_CLK_DIV, 25, clk cycles per MDC half-period (>=2)
C_PREAMBLE_TIME, 32, preamble ones per frame (0..32; 0 = suppressed)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when valid&ready
cmd_channel  in  C_CH_WIDTH  target bus index
cmd_op  in  2  Clause 22: 01 write, 10 read; 00/11 illegal
cmd_c45  in  1  frame type select: 1 = Clause 45
cmd_phy  in  5  PHYAD (PRTAD in C45)
cmd_reg  in  5  REGAD (DEVAD in C45)
cmd_wdata  in  16  write data (address in C45 address op)
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumed
rsp_rdata  out  16  read data; 0 for writes and errors
rsp_error  out  1  illegal command or no PHY TA acknowledge
busy  out  1  frame in progress or response pending
mdc  out  C_NUM_CHANNELS  per-bus MDC
mdio_i  in  C_NUM_CHANNELS  per-bus MDIO input from IOBUF
mdio_o  out  C_NUM_CHANNELS  per-bus MDIO output
mdio_t  out  C_NUM_CHANNELS  per-bus tristate enable; 1 = released

Behaviour:
- Reset values:
  - cmd_ready=1; rsp_valid=0, rsp_rdata=0, rsp_error=0, busy=0.
  - All mdc=0, mdio_o=1, mdio_t=1.
- Reset mid-frame: aborts on the next edge. Bus is released, MDC is forced low, and any pending response is discarded.
- cmd_ready=1 only in IDLE with no pending response. A command is accepted on the clk edge T0 where cmd_valid&cmd_ready.
- Illegal command:
  - Conditions: cmd_channel>=C_NUM_CHANNELS, or C22 op 00/11, or cmd_c45=1 without the macro.
  - Action: no bus activity; rsp_valid=1 at T0+1 with rsp_error=1 and rsp_rdata=0.
- Bit timing:
  - Each bit = MDC low for C_CLK_DIV cycles, then high for C_CLK_DIV cycles. The first low phase starts at T0+1.
  - mdio_o/mdio_t update at the start of the low phase.
  - mdio_i is sampled on the last clk cycle of the high phase (just before MDC falls).
- States: IDLE -> PRE (C_PREAMBLE_TIME ones, skipped if 0) -> HDR (ST 01, OP, PHY[4:0], REG[4:0], MSB first, 14 bits) -> TA -> DATA (16 bits, MSB first) -> RESP -> IDLE.
- Write frame: TA driven 1,0; data driven from cmd_wdata.
- Read frame:
  - mdio_t=1 from the first TA bit through the last data bit.
  - The second TA bit is sampled; if it is 1 (no PHY), rsp_error=1. Data is still clocked and rsp_rdata is forced to 0.
- Frame end:
  - rsp_valid rises at T0+1+(C_PREAMBLE_TIME+32)*2*C_CLK_DIV.
  - MDC stays low and mdio_t=1 after the frame.
- Response hold: rsp_* are held stable until rsp_ready.
- Back-to-back commands: the next cmd_ready rises the cycle after the rsp_valid&rsp_ready handshake.
- Unselected channels: mdc=0 and mdio_t=1 at all times; only the selected channel toggles.
- busy = (state!=IDLE) | rsp_valid.
- Simultaneous rsp handshake and new cmd_valid: the command is not accepted in that cycle.

Optional Feature:
MDIO_CLAUSE45_EN.
- Defined: cmd_c45=1 selects a Clause 45 frame.
  - ST=00; OP 00 address, 01 write, 11 read, 10 post-read-increment.
  - PRTAD=cmd_phy, DEVAD=cmd_reg; TA and data handling as in C22.
  - Address op drives cmd_wdata; 11/10 release the bus and read.
  - All four ops are legal.
- Undefined: cmd_c45=1 is reported as illegal (immediate rsp_error=1). No C45 logic is synthesised.

Test Plan:
- C_CLK_DIV=2, C_PREAMBLE_TIME=32, C22 write ch1 phy=0x03 reg=0x04 wdata=0xA5C3 -> ch1 shows 32 ones, then 01 01 00011 00100 10 1010010111000011; ch0 stays mdc=0/mdio_t=1; rsp_valid at T0+257 with err=0, rdata=0.
- C22 read ch0 phy=0x01 reg=0x02; bench PHY drives TA 0 then 0x1234 -> mdio_t=1 from TA onward; rsp_rdata=0x1234, rsp_error=0.
- Read with no PHY (mdio_i pulled high) -> rsp_error=1, rsp_rdata=0x0000.
- cmd_channel=C_NUM_CHANNELS, or cmd_op=00 -> rsp_valid at T0+1, rsp_error=1, no MDC edges on any channel.
- C_PREAMBLE_TIME=0 write, with rsp_ready held low 10 cycles -> frame is 32 bits (rsp at T0+129); response stable and cmd_ready=0 until handshake; rst asserted mid-frame on the next command -> mdc=0, mdio_t=1, rsp_valid=0 the cycle after.
- MDIO_CLAUSE45_EN: C45 address op (00) ch0 prtad=2 devad=1 data=0x0010, then read (11) -> first frame 00 00 00010 00001 10 0x0010; second frame releases at TA and returns PHY data; without the macro, the same command gives an immediate error.

Source files
------------

// File: rtl/mdio_master_mc_if.sv
// mdio_master_mc_if: command/response handshake bundle between a sequencer and the MDIO master.
interface mdio_master_mc_if #(
    parameter int C_CH_WIDTH = 4
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [C_CH_WIDTH-1:0] cmd_channel;
    logic [1:0]            cmd_op;
    logic                  cmd_c45;
    logic [4:0]            cmd_phy;
    logic [4:0]            cmd_reg;
    logic [15:0]           cmd_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [15:0]           rsp_rdata;
    logic                  rsp_error;
    logic                  busy;

    modport master (
        output cmd_valid, cmd_channel, cmd_op, cmd_c45, cmd_phy, cmd_reg, cmd_wdata, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_error, busy
    );

    modport slave (
        input  cmd_valid, cmd_channel, cmd_op, cmd_c45, cmd_phy, cmd_reg, cmd_wdata, rsp_ready,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_error, busy
    );
endinterface

// File: rtl/mdio_master_mc.sv
// mdio_master_mc: multi-channel Clause 22 MDIO master with internal MDC divider.
// Define MDIO_CLAUSE45_EN to accept Clause 45 frames (cmd_c45=1); otherwise they are rejected.
// Frame outputs are decoded from the registered FSM state, bit counter and shift register,
// so the selected bus toggles while every other channel stays parked (mdc=0, released).
module mdio_master_mc #(
    parameter int C_NUM_CHANNELS  = 2,
    parameter int C_CH_WIDTH      = 4,
    parameter int C_CLK_DIV       = 25,
    parameter int C_PREAMBLE_TIME = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    mdio_master_mc_if.slave           bus,
    output logic [C_NUM_CHANNELS-1:0] mdc,
    input  logic [C_NUM_CHANNELS-1:0] mdio_i,
    output logic [C_NUM_CHANNELS-1:0] mdio_o,
    output logic [C_NUM_CHANNELS-1:0] mdio_t
);
    localparam int DW = $clog2(2 * C_CLK_DIV);
    localparam logic [DW-1:0] DIV_HI  = DW'(C_CLK_DIV);
    localparam logic [DW-1:0] DIV_END = DW'(2 * C_CLK_DIV - 1);
    localparam logic [4:0]    PRE_LAST = 5'(C_PREAMBLE_TIME - 1);

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_HDR, S_TA, S_DATA, S_RESP} state_t;

    state_t                  state, state_n;
    logic [DW-1:0]           div;
    logic [4:0]              bit_cnt;
    logic [31:0]             tx;
    logic [15:0]             rx;
    logic [C_CH_WIDTH-1:0]   ch;
    logic                    rd;
    logic                    ta_err;
    logic [15:0]             rsp_rdata_q;
    logic                    rsp_error_q;
    logic [C_NUM_CHANNELS-1:0] sel;
    logic                    accept;
    logic                    illegal;
    logic                    cmd_rd;
    logic [1:0]              st;
    logic                    bit_end;
    logic                    last_bit;
    logic                    frame;
    logic                    drive;
    logic                    drv_bit;
    logic                    mdio_in;

`ifdef MDIO_CLAUSE45_EN
    assign st      = bus.cmd_c45 ? 2'b00 : 2'b01;
    assign cmd_rd  = bus.cmd_c45 ? bus.cmd_op[1] : (bus.cmd_op == 2'b10);
    assign illegal = (32'(bus.cmd_channel) >= C_NUM_CHANNELS) |
                     (~bus.cmd_c45 & (bus.cmd_op[1] == bus.cmd_op[0]));
`else
    assign st      = 2'b01;
    assign cmd_rd  = bus.cmd_op == 2'b10;
    assign illegal = (32'(bus.cmd_channel) >= C_NUM_CHANNELS) | bus.cmd_c45 |
                     (bus.cmd_op[1] == bus.cmd_op[0]);
`endif

    // Bit-phase decode shared by the FSM, datapath and pin drivers
    always_comb begin
        accept   = bus.cmd_valid & bus.cmd_ready;
        bit_end  = div == DIV_END;
        last_bit = state == S_PRE ? bit_cnt == PRE_LAST :
                   state == S_HDR ? bit_cnt == 5'd13 :
                   state == S_TA  ? bit_cnt == 5'd1 : bit_cnt == 5'd15;
        frame    = state inside {S_PRE, S_HDR, S_TA, S_DATA};
        drive    = (state == S_PRE) | (state == S_HDR) | (((state == S_TA) | (state == S_DATA)) & ~rd);
        drv_bit  = (state == S_PRE) | tx[31];
        mdio_in  = |(mdio_i & sel);
    end

    // Next-state logic: each frame segment advances after its last bit completes
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: if (accept) state_n = illegal ? S_RESP : (C_PREAMBLE_TIME == 0 ? S_HDR : S_PRE);
            S_PRE:  if (bit_end && last_bit) state_n = S_HDR;
            S_HDR:  if (bit_end && last_bit) state_n = S_TA;
            S_TA:   if (bit_end && last_bit) state_n = S_DATA;
            S_DATA: if (bit_end && last_bit) state_n = S_RESP;
            S_RESP: if (bus.rsp_ready) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // State register; reset drops any frame or pending response immediately
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    // Frame datapath: divider, bit counter, tx/rx shifters and response capture
    always_ff @(posedge clk) begin
        if (rst) begin
            div         <= '0;
            bit_cnt     <= '0;
            tx          <= '0;
            rx          <= '0;
            ch          <= '0;
            rd          <= 1'b0;
            ta_err      <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
        end else if (accept) begin
            div         <= '0;
            bit_cnt     <= '0;
            tx          <= {st, bus.cmd_op, bus.cmd_phy, bus.cmd_reg, 2'b10, bus.cmd_wdata};
            rx          <= '0;
            ch          <= bus.cmd_channel;
            rd          <= cmd_rd;
            ta_err      <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_error_q <= illegal;
        end else if (frame) begin
            div <= bit_end ? '0 : div + 1'b1;
            if (bit_end) begin
                bit_cnt <= last_bit ? 5'd0 : bit_cnt + 5'd1;
                if (state != S_PRE) tx <= {tx[30:0], 1'b1};
                if (state == S_TA && last_bit) ta_err <= mdio_in;
                if (state == S_DATA) rx <= {rx[14:0], mdio_in};
                if (state == S_DATA && last_bit) begin
                    rsp_error_q <= rd & ta_err;
                    rsp_rdata_q <= (rd & ~ta_err) ? {rx[14:0], mdio_in} : 16'h0000;
                end
            end
        end
    end

    assign bus.cmd_ready = state == S_IDLE;
    assign bus.rsp_valid = state == S_RESP;
    assign bus.busy      = state != S_IDLE;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_error = rsp_error_q;

    for (genvar i = 0; i < C_NUM_CHANNELS; i++) begin : g_ch
        assign sel[i]    = ch == C_CH_WIDTH'(i);
        assign mdc[i]    = sel[i] & frame & (div >= DIV_HI);
        assign mdio_t[i] = ~(sel[i] & drive);
        assign mdio_o[i] = ~(sel[i] & drive) | drv_bit;
    end
endmodule

// File: tb/tb_mdio_master_mc.sv
// tb_mdio_master_mc: directed bench for mdio_master_mc with 32-bit and suppressed preamble instances.
module tb_mdio_master_mc;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] mdc0, mo0, mt0, mdc1, mo1, mt1;
    logic [1:0] mi0 = 2'b11;
    logic [1:0] mi1 = 2'b11;
    int         cmp_cnt = 0;
    int         err_cnt = 0;

    mdio_master_mc_if #(.C_CH_WIDTH(4)) if0 ();
    mdio_master_mc_if #(.C_CH_WIDTH(4)) if1 ();

    mdio_master_mc #(.C_NUM_CHANNELS(2), .C_CH_WIDTH(4), .C_CLK_DIV(2), .C_PREAMBLE_TIME(32)) u0 (
        .clk(clk), .rst(rst), .bus(if0), .mdc(mdc0), .mdio_i(mi0), .mdio_o(mo0), .mdio_t(mt0)
    );

    mdio_master_mc #(.C_NUM_CHANNELS(2), .C_CH_WIDTH(4), .C_CLK_DIV(2), .C_PREAMBLE_TIME(0)) u1 (
        .clk(clk), .rst(rst), .bus(if1), .mdc(mdc1), .mdio_i(mi1), .mdio_o(mo1), .mdio_t(mt1)
    );

    always #5 clk = ~clk;

    task automatic send(input int d, input logic [3:0] ch, input logic [1:0] op, input logic c45,
                        input logic [4:0] phy, input logic [4:0] rg, input logic [15:0] wd);
        if (d == 0) begin
            if0.cmd_channel = ch; if0.cmd_op = op; if0.cmd_c45 = c45;
            if0.cmd_phy = phy; if0.cmd_reg = rg; if0.cmd_wdata = wd; if0.cmd_valid = 1'b1;
        end else begin
            if1.cmd_channel = ch; if1.cmd_op = op; if1.cmd_c45 = c45;
            if1.cmd_phy = phy; if1.cmd_reg = rg; if1.cmd_wdata = wd; if1.cmd_valid = 1'b1;
        end
        @(posedge clk); #1;
        if0.cmd_valid = 1'b0;
        if1.cmd_valid = 1'b0;
    endtask

    task automatic consume(input int d);
        if (d == 0) if0.rsp_ready = 1'b1; else if1.rsp_ready = 1'b1;
        @(posedge clk); #1;
        if0.rsp_ready = 1'b0;
        if1.rsp_ready = 1'b0;
    endtask

    task automatic capture(input int d, input int ch, input int n, input logic [63:0] phy,
                           output logic [63:0] go, output logic [63:0] gt, output int bad);
        logic [1:0] m, o, t;
        logic       rv;
        go = '0; gt = '0; bad = 0;
        for (int b = 0; b < n; b++) begin
            for (int c = 0; c < 4; c++) begin
                m  = d != 0 ? mdc1 : mdc0;
                o  = d != 0 ? mo1 : mo0;
                t  = d != 0 ? mt1 : mt0;
                rv = d != 0 ? if1.rsp_valid : if0.rsp_valid;
                if (c == 0) begin
                    go[n-1-b] = o[ch];
                    gt[n-1-b] = t[ch];
                    if (d != 0) mi1[ch] = phy[n-1-b]; else mi0[ch] = phy[n-1-b];
                end
                if (m[ch] !== (c >= 2)) bad++;
                if (m[1-ch] !== 1'b0 || t[1-ch] !== 1'b1) bad++;
                if (rv !== 1'b0) bad++;
                @(posedge clk); #1;
            end
        end
        mi0 = 2'b11;
        mi1 = 2'b11;
    endtask

    task automatic test_reset;
        cmp_cnt++;
        if ({if0.cmd_ready, if0.rsp_valid, if0.rsp_error, if0.busy, if0.rsp_rdata} !== {4'b1000, 16'h0}) begin
            err_cnt++;
            $display("FAIL reset_rsp: got %b/%h want 1000/0000",
                     {if0.cmd_ready, if0.rsp_valid, if0.rsp_error, if0.busy}, if0.rsp_rdata);
        end
        cmp_cnt++;
        if ({mdc0, mo0, mt0, mdc1, mo1, mt1} !== 12'b001111_001111) begin
            err_cnt++;
            $display("FAIL reset_pins: got %b want 001111001111", {mdc0, mo0, mt0, mdc1, mo1, mt1});
        end
    endtask

    task automatic test_write;
        logic [63:0] go, gt, exp;
        int bad;
        exp = {32'hFFFF_FFFF, 2'b01, 2'b01, 5'd3, 5'd4, 2'b10, 16'hA5C3};
        send(0, 4'd1, 2'b01, 1'b0, 5'd3, 5'd4, 16'hA5C3);
        capture(0, 1, 64, 64'hFFFF_FFFF_FFFF_FFFF, go, gt, bad);
        cmp_cnt++;
        if (go !== exp) begin err_cnt++; $display("FAIL wr_mdio_o: got %h want %h", go, exp); end
        cmp_cnt++;
        if (gt !== 64'h0) begin err_cnt++; $display("FAIL wr_mdio_t: got %h want 0", gt); end
        cmp_cnt++;
        if (bad !== 0) begin err_cnt++; $display("FAIL wr_timing: got %0d bad cycles want 0", bad); end
        cmp_cnt++;
        if ({if0.rsp_valid, if0.rsp_error, if0.cmd_ready, if0.busy, if0.rsp_rdata} !== {4'b1001, 16'h0}) begin
            err_cnt++;
            $display("FAIL wr_rsp: got %b/%h want 1001/0000",
                     {if0.rsp_valid, if0.rsp_error, if0.cmd_ready, if0.busy}, if0.rsp_rdata);
        end
        cmp_cnt++;
        if ({mdc0, mt0} !== 4'b0011) begin err_cnt++; $display("FAIL wr_idle_pins: got %b want 0011", {mdc0, mt0}); end
        consume(0);
        cmp_cnt++;
        if ({if0.cmd_ready, if0.rsp_valid, if0.busy} !== 3'b100) begin
            err_cnt++;
            $display("FAIL wr_b2b_ready: got %b want 100", {if0.cmd_ready, if0.rsp_valid, if0.busy});
        end
    endtask

    task automatic test_read;
        logic [63:0] go, gt, exp;
        int bad;
        exp = {32'hFFFF_FFFF, 2'b01, 2'b10, 5'd1, 5'd2, 18'h3FFFF};
        send(0, 4'd0, 2'b10, 1'b0, 5'd1, 5'd2, 16'hFFFF);
        capture(0, 0, 64, {46'h3FFF_FFFF_FFFF, 2'b10, 16'h1234}, go, gt, bad);
        cmp_cnt++;
        if (go !== exp) begin err_cnt++; $display("FAIL rd_mdio_o: got %h want %h", go, exp); end
        cmp_cnt++;
        if (gt !== 64'h3FFFF) begin err_cnt++; $display("FAIL rd_mdio_t: got %h want 3ffff", gt); end
        cmp_cnt++;
        if (bad !== 0) begin err_cnt++; $display("FAIL rd_timing: got %0d bad cycles want 0", bad); end
        cmp_cnt++;
        if ({if0.rsp_valid, if0.rsp_error, if0.rsp_rdata} !== {2'b10, 16'h1234}) begin
            err_cnt++;
            $display("FAIL rd_rsp: got %b/%h want 10/1234", {if0.rsp_valid, if0.rsp_error}, if0.rsp_rdata);
        end
        consume(0);
    endtask

    task automatic test_no_phy;
        logic [63:0] go, gt;
        int bad;
        send(0, 4'd0, 2'b10, 1'b0, 5'd7, 5'd9, 16'h0000);
        capture(0, 0, 64, 64'hFFFF_FFFF_FFFF_FFFF, go, gt, bad);
        cmp_cnt++;
        if ({if0.rsp_valid, if0.rsp_error, if0.rsp_rdata, bad} !== {2'b11, 16'h0, 32'd0}) begin
            err_cnt++;
            $display("FAIL nophy_rsp: got %b/%h bad=%0d want 11/0000 bad=0",
                     {if0.rsp_valid, if0.rsp_error}, if0.rsp_rdata, bad);
        end
        consume(0);
    endtask

    task automatic test_illegal;
        int edges;
        send(0, 4'd2, 2'b01, 1'b0, 5'd1, 5'd1, 16'h1111);
        cmp_cnt++;
        if ({if0.rsp_valid, if0.rsp_error, if0.rsp_rdata} !== {2'b11, 16'h0}) begin
            err_cnt++;
            $display("FAIL ill_chan: got %b/%h want 11/0000", {if0.rsp_valid, if0.rsp_error}, if0.rsp_rdata);
        end
        edges = 0;
        for (int i = 0; i < 8; i++) begin
            if (mdc0 !== 2'b00 || mt0 !== 2'b11) edges++;
            @(posedge clk); #1;
        end
        cmp_cnt++;
        if (edges !== 0) begin err_cnt++; $display("FAIL ill_quiet: got %0d active cycles want 0", edges); end
        if0.rsp_ready = 1'b1;
        if0.cmd_valid = 1'b1; if0.cmd_channel = 4'd0; if0.cmd_op = 2'b01; if0.cmd_c45 = 1'b0;
        @(posedge clk); #1;
        if0.cmd_valid = 1'b0;
        if0.rsp_ready = 1'b0;
        cmp_cnt++;
        if ({if0.rsp_valid, if0.cmd_ready, if0.busy} !== 3'b010) begin
            err_cnt++;
            $display("FAIL ill_simul: got %b want 010", {if0.rsp_valid, if0.cmd_ready, if0.busy});
        end
        send(0, 4'd0, 2'b00, 1'b0, 5'd1, 5'd1, 16'h0);
        cmp_cnt++;
        if ({if0.rsp_valid, if0.rsp_error, if0.rsp_rdata, mdc0} !== {2'b11, 16'h0, 2'b00}) begin
            err_cnt++;
            $display("FAIL ill_op00: got %b/%h want 11/0000", {if0.rsp_valid, if0.rsp_error}, if0.rsp_rdata);
        end
        consume(0);
        send(0, 4'd0, 2'b11, 1'b0, 5'd1, 5'd1, 16'h0);
        cmp_cnt++;
        if ({if0.rsp_valid, if0.rsp_error} !== 2'b11) begin
            err_cnt++;
            $display("FAIL ill_op11: got %b want 11", {if0.rsp_valid, if0.rsp_error});
        end
        consume(0);
`ifndef MDIO_CLAUSE45_EN
        send(0, 4'd0, 2'b00, 1'b1, 5'd2, 5'd1, 16'h0010);
        cmp_cnt++;
        if ({if0.rsp_valid, if0.rsp_error, if0.rsp_rdata} !== {2'b11, 16'h0}) begin
            err_cnt++;
            $display("FAIL ill_c45: got %b/%h want 11/0000", {if0.rsp_valid, if0.rsp_error}, if0.rsp_rdata);
        end
        consume(0);
`endif
    endtask

    task automatic test_no_preamble;
        logic [63:0] go, gt, exp;
        int bad, moved;
        exp = 64'({2'b01, 2'b01, 5'd5, 5'd6, 2'b10, 16'h0F0F});
        send(1, 4'd0, 2'b01, 1'b0, 5'd5, 5'd6, 16'h0F0F);
        capture(1, 0, 32, 64'hFFFF_FFFF, go, gt, bad);
        cmp_cnt++;
        if (go !== exp) begin err_cnt++; $display("FAIL np_mdio_o: got %h want %h", go, exp); end
        cmp_cnt++;
        if ({gt, bad} !== {64'h0, 32'd0}) begin
            err_cnt++;
            $display("FAIL np_timing: got t=%h bad=%0d want t=0 bad=0", gt, bad);
        end
        moved = 0;
        for (int i = 0; i < 10; i++) begin
            if ({if1.rsp_valid, if1.rsp_error, if1.cmd_ready, if1.rsp_rdata} !== {3'b100, 16'h0}) moved++;
            @(posedge clk); #1;
        end
        cmp_cnt++;
        if (moved !== 0) begin err_cnt++; $display("FAIL np_hold: got %0d unstable cycles want 0", moved); end
        consume(1);
        cmp_cnt++;
        if ({if1.rsp_valid, if1.cmd_ready} !== 2'b01) begin
            err_cnt++;
            $display("FAIL np_release: got %b want 01", {if1.rsp_valid, if1.cmd_ready});
        end
    endtask

    task automatic test_reset_mid;
        send(1, 4'd1, 2'b01, 1'b0, 5'd1, 5'd1, 16'hFFFF);
        repeat (6) @(posedge clk);
        #1;
        cmp_cnt++;
        if ({mdc1, mt1} !== 4'b1001) begin err_cnt++; $display("FAIL rm_active: got %b want 1001", {mdc1, mt1}); end
        rst = 1'b1;
        @(posedge clk); #1;
        cmp_cnt++;
        if ({mdc1, mt1, if1.rsp_valid, if1.cmd_ready, if1.busy} !== 7'b0011010) begin
            err_cnt++;
            $display("FAIL rm_abort: got %b want 0011010", {mdc1, mt1, if1.rsp_valid, if1.cmd_ready, if1.busy});
        end
        rst = 1'b0;
    endtask

`ifdef MDIO_CLAUSE45_EN
    task automatic test_c45;
        logic [63:0] go, gt, exp;
        int bad;
        exp = {32'hFFFF_FFFF, 2'b00, 2'b00, 5'd2, 5'd1, 2'b10, 16'h0010};
        send(0, 4'd0, 2'b00, 1'b1, 5'd2, 5'd1, 16'h0010);
        capture(0, 0, 64, 64'hFFFF_FFFF_FFFF_FFFF, go, gt, bad);
        cmp_cnt++;
        if ({go, gt} !== {exp, 64'h0}) begin err_cnt++; $display("FAIL c45_addr: got %h/%h want %h/0", go, gt, exp); end
        consume(0);
        exp = {32'hFFFF_FFFF, 2'b00, 2'b11, 5'd2, 5'd1, 18'h3FFFF};
        send(0, 4'd0, 2'b11, 1'b1, 5'd2, 5'd1, 16'h0000);
        capture(0, 0, 64, {46'h3FFF_FFFF_FFFF, 2'b10, 16'hBEEF}, go, gt, bad);
        cmp_cnt++;
        if ({go, gt} !== {exp, 64'h3FFFF}) begin err_cnt++; $display("FAIL c45_rd_bus: got %h/%h want %h/3ffff", go, gt, exp); end
        cmp_cnt++;
        if ({if0.rsp_valid, if0.rsp_error, if0.rsp_rdata, bad} !== {2'b10, 16'hBEEF, 32'd0}) begin
            err_cnt++;
            $display("FAIL c45_rd_rsp: got %b/%h bad=%0d want 10/beef bad=0",
                     {if0.rsp_valid, if0.rsp_error}, if0.rsp_rdata, bad);
        end
        consume(0);
    endtask
`endif

    initial begin
        if0.cmd_valid = 1'b0; if0.rsp_ready = 1'b0; if0.cmd_channel = '0; if0.cmd_op = '0;
        if0.cmd_c45 = 1'b0; if0.cmd_phy = '0; if0.cmd_reg = '0; if0.cmd_wdata = '0;
        if1.cmd_valid = 1'b0; if1.rsp_ready = 1'b0; if1.cmd_channel = '0; if1.cmd_op = '0;
        if1.cmd_c45 = 1'b0; if1.cmd_phy = '0; if1.cmd_reg = '0; if1.cmd_wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        test_reset;
        test_write;
        test_read;
        test_no_phy;
        test_illegal;
        test_no_preamble;
        test_reset_mid;
`ifdef MDIO_CLAUSE45_EN
        test_c45;
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end
endmodule
